// File: rtl/sequential_multiplier.sv
// rtl/sequential_multiplier.sv - radix-2 Booth signed sequential multiplier, one step per clock
// Optional feature macro: SEQ_MULT_DONE_EN adds the 'done' output and its register.
// rst is synchronous, active-high and doubles as the load/start command.
// prod is never cleared by rst; it only changes on the completing Booth step.
// The zero encoding of the state register is IDLE, so a zero power-up state
// leaves the block idle with prod (and done) reading 0 until the first result.

module sequential_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic [2*WIDTH-1:0]   prod
`ifdef SEQ_MULT_DONE_EN
  ,
  output logic                 done
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  // One guard bit above the accumulator keeps A +/- M exact when M is the most negative value.
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mplier;
  logic               q_prev;
  logic [2*WIDTH-1:0] prod_r;

  logic [WIDTH:0]     mcand_ext;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   mplier_next;
  logic               q_prev_next;

  // One Booth step: add/subtract the multiplicand per the recoded bit pair, then arithmetic shift right.
  always_comb begin
    mcand_ext = {mcand[WIDTH-1], mcand};
    case ({mplier[0], q_prev})
      2'b01:   sum = acc + mcand_ext;
      2'b10:   sum = acc - mcand_ext;
      default: sum = acc;
    endcase
    acc_next    = {sum[WIDTH], sum[WIDTH:1]};
    mplier_next = {sum[0], mplier[WIDTH-1:1]};
    q_prev_next = mplier[0];
  end

  // Load on rst, step through RUN, publish the product only on the last step, then hold in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_LOAD;
      mcand  <= in1;
      mplier <= in2;
      acc    <= '0;
      q_prev <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        S_LOAD, S_RUN: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          q_prev <= q_prev_next;
          if (count == LAST_STEP) begin
            // The full product fits in 2*WIDTH bits, so the guard bit can be dropped here.
            prod_r <= {acc_next[WIDTH-1:0], mplier_next};
            state  <= S_IDLE;
          end else begin
            count <= count + 1'b1;
            state <= S_RUN;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign prod = prod_r;

`ifdef SEQ_MULT_DONE_EN
  logic done_r;

  // done rises with the completing step, holds through IDLE and drops on any rst edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r <= 1'b0;
    end else if ((state == S_LOAD || state == S_RUN) && count == LAST_STEP) begin
      done_r <= 1'b1;
    end
  end

  assign done = done_r;
`endif

endmodule

// File: tb/tb_sequential_multiplier.sv
// tb/tb_sequential_multiplier.sv - randomized self-checking bench for sequential_multiplier

module tb_sequential_multiplier;

  localparam int WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [2*WIDTH-1:0] prod;
`ifdef SEQ_MULT_DONE_EN
  logic               done;
`endif

  int     n_cmp = 0;
  int     n_bad = 0;
  longint last_prod = 0;
  logic   last_done = 1'b0;

  sequential_multiplier #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .in1  (in1),
    .in2  (in2),
    .prod (prod)
`ifdef SEQ_MULT_DONE_EN
    ,
    .done (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_done(input string tag, input logic exp);
`ifdef SEQ_MULT_DONE_EN
    check_eq({tag, "/done"}, {63'b0, done}, {63'b0, exp});
`endif
  endtask

  function automatic int pick_operand();
    int sel;
    sel = int'($urandom_range(0, 6));
    case (sel)
      0:       return 0;
      1:       return int'(32'h8000_0000);
      2:       return -1;
      3:       return 1;
      4:       return int'(32'h7FFF_FFFF);
      default: return int'($urandom);
    endcase
  endfunction

  // Hold rst for 'hold' edges (real operands only on the last one), then let it run 'run' edges.
  // The reference is plain signed 64-bit arithmetic; prod must change only on the 32nd run edge.
  task automatic run_op(input int a, input int b, input int hold, input int run, input string tag);
    longint expv;
    expv = longint'(a) * longint'(b);
    for (int i = 0; i < hold; i++) begin
      rst = 1'b1;
      if (i == hold - 1) begin
        in1 = a;
        in2 = b;
      end else begin
        in1 = $urandom;
        in2 = $urandom;
      end
      @(posedge clk);
      #2;
      check_eq({tag, "/rst"}, prod, last_prod);
      last_done = 1'b0;
      check_done({tag, "/rst"}, last_done);
    end
    rst = 1'b0;
    in1 = $urandom;
    in2 = $urandom;
    for (int k = 1; k <= run; k++) begin
      @(posedge clk);
      #2;
      if (k == 32) begin
        last_prod = expv;
        last_done = 1'b1;
      end
      check_eq(tag, prod, last_prod);
      check_done(tag, last_done);
      if (k % 7 == 0) begin
        in1 = $urandom;
        in2 = $urandom;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    in1 = '0;
    in2 = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check_eq("init_zero", prod, 64'd0);
      check_done("init_zero", 1'b0);
    end

    run_op(2, 5, 12, 40, "hold12_2x5");
    check_eq("hold12_const", prod, 64'd10);

    run_op(4, -3, 1, 40, "seq_4x-3");
    run_op(-7, 6, 1, 40, "seq_-7x6");
    check_eq("seq_-7x6_const", prod, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op(-7, -2, 1, 40, "seq_-7x-2");
    run_op(3, 0, 1, 40, "seq_3x0");

    run_op(int'(32'h8000_0000), int'(32'h8000_0000), 1, 40, "min_x_min");
    check_eq("min_x_min_const", prod, 64'h4000_0000_0000_0000);
    run_op(int'(32'h8000_0000), 1, 2, 40, "min_x_1");
    check_eq("min_x_1_const", prod, 64'hFFFF_FFFF_8000_0000);

    run_op(5, 5, 1, 40, "ignore_inputs");
    check_eq("ignore_inputs_const", prod, 64'd25);

    run_op(1, 8, 1, 10, "abort_1x8");
    run_op(3, 7, 1, 40, "restart_3x7");
    check_eq("restart_const", prod, 64'd21);

    for (int t = 0; t < 40; t++) begin
      run_op(pick_operand(), pick_operand(), int'($urandom_range(1, 3)),
             int'($urandom_range(20, 40)), "random");
    end

    run_op(-1, -1, 1, 34, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
